phy_mdio_init: RTL and testbench



---
 rtl/phy_mdio_init_pkg.sv | 48 ++++
 rtl/phy_mdio_init_frame_engine.sv | 133 +++++++++++++
 rtl/phy_mdio_init.sv | 133 +++++++++++++
 tb/tb_phy_mdio_init.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_mdio_init_pkg.sv
// Shared MDIO/SMI definitions for the PHY initialiser: frame fields, PHY register map and
// the top-level sequencing states.
package phy_mdio_init_pkg;

  // Clause 22 frame fields.
  localparam logic [1:0] MdioSt   = 2'b01;
  localparam logic [1:0] MdioOpWr = 2'b01;
  localparam logic [1:0] MdioOpRd = 2'b10;

  // PHY registers used during bring-up.
  localparam logic [4:0]  RegBmcr     = 5'd0;
  localparam logic [4:0]  RegBmsr     = 5'd1;
  localparam int unsigned BmsrLinkBit = 2;
  // 100 Mb/s, full duplex, autonegotiation off.
  localparam logic [15:0] BmcrDefault = 16'h2100;

  // Frame geometry, bit indices counted from the first preamble bit.
  localparam int unsigned FrameBits = 64;
  localparam int unsigned RdRelease = 46;  // first TA bit: host releases the bus on reads
  localparam int unsigned DataFirst = 48;  // first data bit

  typedef enum logic [2:0] {
    StWait,
    StWrBmcr,
    StGap,
    StRdBmsr,
    StReady
  } init_state_e;

  // Full 64-bit frame, MSB transmitted first. Read frames carry all-ones after ST/OP/addresses
  // so the output stays at the idle level once the bus is released.
  function automatic logic [FrameBits-1:0] mdio_frame(input logic [1:0]  op,
                                                       input logic [4:0]  phy_addr,
                                                       input logic [4:0]  reg_addr,
                                                       input logic [15:0] data);
    logic [1:0]  ta;
    logic [15:0] d;
    ta = (op == MdioOpWr) ? 2'b10 : 2'b11;
    d  = (op == MdioOpWr) ? data  : 16'hFFFF;
    return {32'hFFFF_FFFF, MdioSt, op, phy_addr, reg_addr, ta, d};
  endfunction

  // An absent PHY reads as all-ones, which must not be mistaken for link up.
  function automatic logic link_up(input logic [15:0] bmsr);
    return bmsr[BmsrLinkBit] && (bmsr != 16'hFFFF);
  endfunction

endpackage

// File: rtl/phy_mdio_init_frame_engine.sv
// MDIO frame engine: shifts one 64-bit management frame out MSB first, two clock cycles per
// bit (MDC low then high). On reads it releases the pad at the turnaround and shifts the
// 16 data bits in on each MDC falling edge. All pin outputs are registered.
module mdio_frame_engine
  import phy_mdio_init_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [1:0]  op_i,
  input  logic [4:0]  phy_addr_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [15:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        mdc_o,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe_o
);

  localparam logic [5:0] LastBit = 6'(FrameBits - 1);
  localparam logic [5:0] RelBit  = 6'(RdRelease);
  localparam logic [5:0] DataBit = 6'(DataFirst);

  logic                 busy_q, busy_d;
  logic                 is_rd_q, is_rd_d;
  logic                 phase_q, phase_d;
  logic [5:0]           bit_q, bit_d;
  logic [FrameBits-1:0] shift_q, shift_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 done_q, done_d;
  logic                 mdc_q, mdc_d;
  logic                 mdio_q, mdio_d;
  logic                 oe_q, oe_d;
  logic [FrameBits-1:0] frame;
  logic [5:0]           bit_nxt;

  assign frame   = mdio_frame(op_i, phy_addr_i, reg_addr_i, wdata_i);
  assign bit_nxt = bit_q + 6'd1;

  // Bit sequencing: phase 0 presents data with MDC low, phase 1 raises MDC; the edge that
  // closes phase 1 samples read data and moves to the next bit.
  always_comb begin
    busy_d  = busy_q;
    is_rd_d = is_rd_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mdc_d   = mdc_q;
    mdio_d  = mdio_q;
    oe_d    = oe_q;
    if (abort_i) begin
      busy_d  = 1'b0;
      phase_d = 1'b0;
      bit_d   = '0;
      mdc_d   = 1'b0;
      mdio_d  = 1'b1;
      oe_d    = 1'b0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_d  = 1'b1;
        is_rd_d = (op_i == MdioOpRd);
        phase_d = 1'b0;
        bit_d   = '0;
        shift_d = frame << 1;
        rdata_d = '0;
        mdc_d   = 1'b0;
        mdio_d  = frame[FrameBits-1];
        oe_d    = 1'b1;
      end
    end else if (!phase_q) begin
      phase_d = 1'b1;
      mdc_d   = 1'b1;
    end else begin
      phase_d = 1'b0;
      mdc_d   = 1'b0;
      if (is_rd_q && (bit_q >= DataBit)) begin
        rdata_d = {rdata_q[14:0], mdio_i};
      end
      if (bit_q == LastBit) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        mdio_d = 1'b1;
        oe_d   = 1'b0;
      end else begin
        bit_d   = bit_nxt;
        mdio_d  = shift_q[FrameBits-1];
        shift_d = shift_q << 1;
        oe_d    = !(is_rd_q && (bit_nxt >= RelBit));
      end
    end
  end

  // Engine state and registered pin drivers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      is_rd_q <= 1'b0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mdc_q   <= 1'b0;
      mdio_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      is_rd_q <= is_rd_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mdc_q   <= mdc_d;
      mdio_q  <= mdio_d;
      oe_q    <= oe_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign mdc_o     = mdc_q;
  assign mdio_o    = mdio_q;
  assign mdio_oe_o = oe_q;

endmodule

// File: rtl/phy_mdio_init.sv
// PHY management initialiser: waits for the PHY to settle after hardware reset, forces
// 100M full duplex through BMCR, then polls BMSR until link is up and raises a sticky ready.
module phy_mdio_init
  import phy_mdio_init_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] BMCR_VAL = BmcrDefault,
  parameter int unsigned RST_WAIT = 10000,
  parameter int unsigned POLL_GAP = 1000
) (
  input  logic clk1m,
  input  logic rst,
  input  logic phyrst,
  output logic ready,
  output logic mdc_o,
  input  logic mdio_i,
  output logic mdio_o,
  output logic mdio_out_en
);

  localparam int unsigned    CntMax      = (RST_WAIT > POLL_GAP) ? RST_WAIT : POLL_GAP;
  localparam int unsigned    CntW        = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] RstWaitLast = CntW'(RST_WAIT - 1);
  localparam logic [CntW-1:0] PollGapLast = CntW'(POLL_GAP - 1);

  init_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;

  logic        eng_start;
  logic [1:0]  eng_op;
  logic [4:0]  eng_reg;
  logic        eng_busy;
  logic        eng_done;
  logic [15:0] eng_rdata;

  // Sequencing: settle wait, BMCR write, then gap/poll loop on BMSR until link is up.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    eng_start = 1'b0;
    eng_op    = MdioOpWr;
    eng_reg   = RegBmcr;
    unique case (state_q)
      StWait: begin
        if ((cnt_q == RstWaitLast) && !eng_busy) begin
          state_d   = StWrBmcr;
          cnt_d     = '0;
          eng_start = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrBmcr: begin
        if (eng_done) begin
          state_d = StGap;
          // The cycle that observes done is already the first idle cycle.
          cnt_d   = CntW'(1);
        end
      end
      StGap: begin
        if ((cnt_q >= PollGapLast) && !eng_busy) begin
          state_d   = StRdBmsr;
          cnt_d     = '0;
          eng_start = 1'b1;
          eng_op    = MdioOpRd;
          eng_reg   = RegBmsr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdBmsr: begin
        if (eng_done) begin
          if (link_up(eng_rdata)) begin
            state_d = StReady;
            ready_d = 1'b1;
          end else begin
            state_d = StGap;
            cnt_d   = CntW'(1);
          end
        end
      end
      StReady: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
    // PHY held in reset: restart the whole bring-up unless already done.
    if (!phyrst && (state_q != StReady)) begin
      state_d   = StWait;
      cnt_d     = '0;
      eng_start = 1'b0;
    end
  end

  // Sequencer state, counter and sticky ready flag.
  always_ff @(posedge clk1m or negedge rst) begin
    if (!rst) begin
      state_q <= StWait;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  mdio_frame_engine u_engine (
    .clk_i      (clk1m),
    .rst_ni     (rst),
    .start_i    (eng_start),
    .abort_i    (!phyrst),
    .op_i       (eng_op),
    .phy_addr_i (PHY_ADDR),
    .reg_addr_i (eng_reg),
    .wdata_i    (BMCR_VAL),
    .busy_o     (eng_busy),
    .done_o     (eng_done),
    .rdata_o    (eng_rdata),
    .mdc_o      (mdc_o),
    .mdio_i     (mdio_i),
    .mdio_o     (mdio_o),
    .mdio_oe_o  (mdio_out_en)
  );

  assign ready = ready_q;

endmodule

// File: tb/tb_phy_mdio_init.sv
// Directed bench for phy_mdio_init with a small PHY model answering BMSR reads.
`timescale 1ns / 1ps
module tb_phy_mdio_init;

  localparam int unsigned RstWait = 20;
  localparam int unsigned PollGap = 8;
  localparam int unsigned FrameCyc = 128;

  logic clk1m  = 1'b0;
  logic rst    = 1'b1;
  logic phyrst = 1'b1;
  logic mdio_i = 1'b1;
  logic ready;
  logic mdc_o;
  logic mdio_o;
  logic mdio_out_en;

  int n_checks = 0;
  int n_pass   = 0;

  // PHY model state
  int          cyc      = 0;
  int          bitn     = 0;
  logic        mdc_prev = 1'b0;
  logic [63:0] cap      = '0;
  int          fstart   = 0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  int          rd_base  = 0;
  logic [63:0] last_rd  = '0;
  logic [63:0] last_wr  = '0;
  int          rd_start [8];
  logic [15:0] resp [8];

  phy_mdio_init #(
    .PHY_ADDR (5'd1),
    .BMCR_VAL (16'h2100),
    .RST_WAIT (RstWait),
    .POLL_GAP (PollGap)
  ) dut (
    .clk1m       (clk1m),
    .rst         (rst),
    .phyrst      (phyrst),
    .ready       (ready),
    .mdc_o       (mdc_o),
    .mdio_i      (mdio_i),
    .mdio_o      (mdio_o),
    .mdio_out_en (mdio_out_en)
  );

  always #500 clk1m = ~clk1m;

  always @(posedge clk1m) cyc <= cyc + 1;

  // PHY model: decodes each frame bit while MDC is high and drives read data after the
  // MDC rising edge so it is stable at the following falling edge.
  always @(negedge clk1m) begin : phy_model
    logic [63:0] c;
    logic [15:0] r;
    int          idx;
    c   = cap;
    idx = rd_cnt - rd_base;
    if (mdc_o) begin
      c[63-bitn] = mdio_o;
      r = resp[idx & 7];
      if (bitn >= 48) mdio_i <= r[63-bitn];
      else            mdio_i <= 1'b1;
      if (bitn == 0) fstart <= cyc;
      if (bitn == 63) begin
        if (c[29:28] == 2'b10) begin
          rd_cnt  <= rd_cnt + 1;
          last_rd <= c;
          if (idx < 8 && idx >= 0) rd_start[idx] <= fstart;
        end else begin
          wr_cnt  <= wr_cnt + 1;
          last_wr <= c;
        end
        bitn <= 0;
      end else begin
        bitn <= bitn + 1;
      end
      cap <= c;
    end else begin
      mdio_i <= 1'b1;
      if (!mdc_prev) bitn <= 0;
    end
    mdc_prev <= mdc_o;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Edges until the bus shows any activity; -1 if none within the budget.
  task automatic wait_active(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk1m);
      #1;
      if (mdio_out_en || mdc_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk1m);
      #1;
      if (!mdio_out_en && !mdc_o) begin
        n = i;
        break;
      end
    end
  endtask

  logic [63:0] exp_wr;
  logic [63:0] fr;
  int          n;
  int          oe_err;
  int          mdc_err;
  int          act;
  int          rcyc;
  int          wr_base;
  logic        got_ready;

  initial begin
    exp_wr = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h2100};
    for (int i = 0; i < 8; i++) begin
      resp[i]     = 16'h782D;
      rd_start[i] = 0;
    end

    // Reset values
    #100 rst = 1'b0;
    #1500;
    check_eq("rst_ready", ready, 1'b0);
    check_eq("rst_mdc", mdc_o, 1'b0);
    check_eq("rst_mdio_o", mdio_o, 1'b1);
    check_eq("rst_oe", mdio_out_en, 1'b0);

    // Settle wait then BMCR write frame
    @(negedge clk1m) rst = 1'b1;
    wait_active(n);
    check_eq("settle_len", n, RstWait);
    oe_err  = 0;
    mdc_err = 0;
    for (int b = 0; b < 64; b++) begin
      fr[63-b] = mdio_o;
      if (mdio_out_en !== 1'b1) oe_err++;
      if (mdc_o !== 1'b0) mdc_err++;
      @(posedge clk1m);
      #1;
      if (mdio_out_en !== 1'b1) oe_err++;
      if (mdc_o !== 1'b1) mdc_err++;
      @(posedge clk1m);
      #1;
    end
    check_eq("wr_oe_all", oe_err, 0);
    check_eq("wr_mdc_pattern", mdc_err, 0);
    check_eq("wr_preamble", fr[63:32], 32'hFFFF_FFFF);
    check_eq("wr_st_op", fr[31:28], 4'b0101);
    check_eq("wr_phy", fr[27:23], 5'd1);
    check_eq("wr_reg", fr[22:18], 5'd0);
    check_eq("wr_ta", fr[17:16], 2'b10);
    check_eq("wr_data", fr[15:0], 16'h2100);
    check_eq("wr_idle_after", {mdio_out_en, mdc_o, mdio_o}, 3'b001);

    // First BMSR read answers link up
    wait_active(n);
    check_eq("poll_gap", n, PollGap);
    oe_err = 0;
    for (int b = 0; b < 64; b++) begin
      if (mdio_out_en !== (b < 46)) oe_err++;
      @(posedge clk1m);
      #1;
      if (mdio_out_en !== (b < 46)) oe_err++;
      @(posedge clk1m);
      #1;
    end
    check_eq("rd_oe_release46", oe_err, 0);
    check_eq("rd_ready_not_yet", ready, 1'b0);
    @(posedge clk1m);
    #1;
    check_eq("rd_ready_rise", ready, 1'b1);
    check_eq("rd_header", last_rd[31:18], {2'b01, 2'b10, 5'd1, 5'd1});
    act = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk1m);
      #1;
      if (mdc_o || mdio_out_en) act++;
    end
    check_eq("ready_bus_quiet", act, 0);
    check_eq("ready_sticky", ready, 1'b1);
    check_eq("ready_one_read", rd_cnt, 1);

    // Async reset while READY
    @(negedge clk1m) rst = 1'b0;
    #1;
    check_eq("rst_in_ready", {ready, mdc_o, mdio_o, mdio_out_en}, 4'b0010);
    resp[0] = 16'h7809;
    resp[1] = 16'h7809;
    resp[2] = 16'h782D;
    rd_base = rd_cnt;
    repeat (3) @(posedge clk1m);
    @(negedge clk1m) rst = 1'b1;
    got_ready = 1'b0;
    rcyc      = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk1m);
      #1;
      if (ready) begin
        got_ready = 1'b1;
        rcyc      = cyc;
        break;
      end
    end
    check_eq("poll3_ready", got_ready, 1'b1);
    check_eq("poll3_reads", rd_cnt - rd_base, 3);
    check_eq("poll3_space01", rd_start[1] - rd_start[0], FrameCyc + PollGap);
    check_eq("poll3_space12", rd_start[2] - rd_start[1], FrameCyc + PollGap);
    check_eq("poll3_ready_lat", rcyc - rd_start[2], FrameCyc);

    // No PHY: all-ones never qualifies
    @(negedge clk1m) rst = 1'b0;
    for (int i = 0; i < 8; i++) resp[i] = 16'hFFFF;
    rd_base = rd_cnt;
    repeat (2) @(posedge clk1m);
    @(negedge clk1m) rst = 1'b1;
    repeat (1000) @(posedge clk1m);
    #1;
    check_eq("nophy_ready_low", ready, 1'b0);
    check_eq("nophy_reads_ge5", (rd_cnt - rd_base) >= 5, 1'b1);

    // PHY reset pulse mid write frame
    @(negedge clk1m) rst = 1'b0;
    #1;
    check_eq("rst_midrun", {ready, mdc_o, mdio_o, mdio_out_en}, 4'b0010);
    wr_base = wr_cnt;
    repeat (2) @(posedge clk1m);
    @(negedge clk1m) rst = 1'b1;
    wait_active(n);
    check_eq("abort_settle1", n, RstWait);
    repeat (30) @(posedge clk1m);
    @(negedge clk1m) phyrst = 1'b0;
    @(posedge clk1m);
    #1;
    check_eq("abort_idle", {mdio_out_en, mdc_o, mdio_o}, 3'b001);
    act = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk1m);
      #1;
      if (mdc_o || mdio_out_en) act++;
    end
    check_eq("abort_hold_idle", act, 0);
    @(negedge clk1m) phyrst = 1'b1;
    wait_active(n);
    check_eq("abort_recount", n, RstWait);
    wait_idle(n);
    check_eq("abort_resend_len", n, FrameCyc);
    check_eq("abort_wr_count", wr_cnt - wr_base, 1);
    check_eq("abort_wr_frame", last_wr, exp_wr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
